// File: rtl/nonce_tx_scheduler.sv
// nonce_tx_scheduler: latches per-source nonces, round-robin merges them
// into a FIFO and drives the serial_transmit send/busy handshake.
module nonce_tx_scheduler #(
    parameter int SLAVES       = 2,
    parameter int FIFO_LOG2    = 3,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SLAVES-1:0]      new_nonces,
    input  logic [SLAVES*32-1:0]   slave_nonces,
    input  logic                   serial_busy,
    output logic                   serial_send,
    output logic [31:0]            golden_nonce,
    output logic [FIFO_LOG2:0]     fifo_count,
    output logic [15:0]            drop_count,
    output logic [7:0]             timeout_count
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int RRW   = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int TW    = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t               state_q;
    logic [SLAVES-1:0]    pend_q;
    logic [31:0]          pnonce_q [SLAVES];
    logic [RRW-1:0]       rr_q;
    logic [31:0]          mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] wp_q;
    logic [FIFO_LOG2-1:0] rp_q;
    logic [FIFO_LOG2:0]   cnt_q;
    logic [15:0]          drop_q;
    logic [15:0]          drop_d;
    logic [7:0]           tout_q;
    logic [TW-1:0]        tmr_q;
    logic                 send_q;
    logic [31:0]          golden_q;

    logic                 grant_vld;
    logic [RRW-1:0]       grant_idx;
    logic [SLAVES-1:0]    gmask;
    logic [SLAVES-1:0]    drop_vec;
    logic [16:0]          drop_sum;
    logic                 full;
    logic                 pop;
    logic                 push;

    // Round-robin search: first pending source after rr_q, wrapping.
    always_comb begin
        int c;
        c         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = SLAVES; k >= 1; k--) begin
            c = (int'(rr_q) + k) % SLAVES;
            if (pend_q[c]) begin
                grant_vld = 1'b1;
                grant_idx = RRW'(c);
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves this cycle.
    assign full = (cnt_q == (FIFO_LOG2 + 1)'(DEPTH));
    assign pop  = (state_q == IDLE) && (cnt_q != '0) && !serial_busy;
    assign push = grant_vld && (!full || pop);

    // Overwrites of a still-pending, ungranted slot count as drops.
    always_comb begin
        gmask = '0;
        if (push) gmask[grant_idx] = 1'b1;
        drop_vec = new_nonces & pend_q & ~gmask;
        drop_sum = {1'b0, drop_q} + 17'($countones(drop_vec));
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Pending flags, arbitration pointer and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            rr_q   <= '0;
            drop_q <= '0;
        end else begin
            pend_q <= (pend_q & ~gmask) | new_nonces;
            if (push) rr_q <= grant_idx;
            drop_q <= drop_d;
        end
    end

    // Data payloads: latched source words and FIFO slots.
    always_ff @(posedge clk) begin
        for (int j = 0; j < SLAVES; j++) begin
            if (new_nonces[j]) pnonce_q[j] <= slave_nonces[j*32 +: 32];
        end
        if (push) mem_q[wp_q] <= pnonce_q[grant_idx];
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
            if (push && !pop) cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Transmit sequencer with registered send strobe and word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            send_q   <= 1'b0;
            golden_q <= '0;
            tmr_q    <= '0;
            tout_q   <= '0;
        end else begin
            send_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        golden_q <= mem_q[rp_q];
                        send_q   <= 1'b1;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    tmr_q   <= '0;
                    state_q <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (serial_busy) begin
                        state_q <= WAIT_LO;
                    end else if (tmr_q == TW'(BUSY_TIMEOUT - 1)) begin
                        if (tout_q != 8'hFF) tout_q <= tout_q + 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!serial_busy) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign serial_send   = send_q;
    assign golden_nonce  = golden_q;
    assign fifo_count    = cnt_q;
    assign drop_count    = drop_q;
    assign timeout_count = tout_q;

endmodule

// File: tb/tb_nonce_tx_scheduler.sv
// tb_nonce_tx_scheduler: scoreboard bench with an arbitration model
// predicting transmit order; a monitor checks every send.
module tb_nonce_tx_scheduler;
    localparam int SLAVES    = 2;
    localparam int FIFO_LOG2 = 3;
    localparam int DEPTH     = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [SLAVES-1:0]    new_nonces = '0;
    logic [SLAVES*32-1:0] slave_nonces = '0;
    logic                 serial_busy;
    logic                 serial_send;
    logic [31:0]          golden_nonce;
    logic [FIFO_LOG2:0]   fifo_count;
    logic [15:0]          drop_count;
    logic [7:0]           timeout_count;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] expq[$];
    bit          mpend[SLAVES];
    logic [31:0] mnon[SLAVES];
    int          mrr = 0;
    int          mdrop = 0;
    int          sends = 0;
    bit          prev_send = 1'b0;
    bit          resp_en = 1'b0;
    bit          man_busy = 1'b0;
    bit          resp_busy = 1'b0;
    int          bcnt = 0;

    assign serial_busy = resp_en ? resp_busy : man_busy;

    always #5 clk = ~clk;

    nonce_tx_scheduler #(
        .SLAVES(SLAVES),
        .FIFO_LOG2(FIFO_LOG2),
        .BUSY_TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .new_nonces(new_nonces),
        .slave_nonces(slave_nonces),
        .serial_busy(serial_busy),
        .serial_send(serial_send),
        .golden_nonce(golden_nonce),
        .fifo_count(fifo_count),
        .drop_count(drop_count),
        .timeout_count(timeout_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: grant the first pending source after the last winner,
    // queue its word, then latch this cycle's strobes.
    task automatic model_edge(input logic [SLAVES-1:0] s,
                              input logic [SLAVES*32-1:0] v);
        int g;
        int c;
        g = -1;
        for (int k = 1; k <= SLAVES; k++) begin
            c = (mrr + k) % SLAVES;
            if (g < 0 && mpend[c]) g = c;
        end
        if (g >= 0 && expq.size() < DEPTH) begin
            expq.push_back(mnon[g]);
            mpend[g] = 1'b0;
            mrr = g;
        end
        for (int j = 0; j < SLAVES; j++) begin
            if (s[j]) begin
                if (mpend[j]) mdrop++;
                mpend[j] = 1'b1;
                mnon[j]  = v[j*32 +: 32];
            end
        end
    endtask

    task automatic step(input logic [SLAVES-1:0] s,
                        input logic [SLAVES*32-1:0] v);
        @(negedge clk);
        new_nonces   = s;
        slave_nonces = v;
        @(posedge clk);
        model_edge(s, v);
        #1;
        new_nonces = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0);
    endtask

    function automatic bit any_pend();
        bit r;
        r = 1'b0;
        for (int j = 0; j < SLAVES; j++) r = r | mpend[j];
        return r;
    endfunction

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((expq.size() != 0 || any_pend()) && n < budget) begin
            step('0, '0);
            n++;
        end
        idle(6);
        chk({name, "_drained"}, 32'(expq.size()), 32'd0);
        chk({name, "_fifo_empty"}, 32'(fifo_count), 32'd0);
    endtask

    // Serial link responder: busy rises after a send for a few cycles.
    always @(negedge clk) begin
        if (!resp_en) bcnt = 0;
        else if (serial_send) bcnt = 2 + int'($urandom_range(0, 2));
        else if (bcnt > 0) bcnt = bcnt - 1;
        resp_busy = (bcnt > 0);
    end

    // Monitor: every send must carry the next expected word.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (serial_send === 1'b1) begin
                sends++;
                chk("send_one_cycle", 32'(prev_send), 32'd0);
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_send actual=%h required=none",
                             golden_nonce);
                end else begin
                    chk("tx_word", golden_nonce, expq.pop_front());
                end
            end
            prev_send = (serial_send === 1'b1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        logic [SLAVES-1:0]    s;
        logic [SLAVES*32-1:0] v;
        logic [31:0]          r0;
        logic [31:0]          r1;

        #1;
        chk("rst_send", 32'(serial_send), 32'd0);
        chk("rst_golden", golden_nonce, 32'd0);
        chk("rst_fifo", 32'(fifo_count), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_tmo", 32'(timeout_count), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        resp_en = 1'b1;

        s0 = sends;
        step(2'b01, {32'h0, 32'hDEADBEEF});
        drain("single", 40);
        chk("single_sends", 32'(sends - s0), 32'd1);

        step(2'b11, {32'h22222222, 32'h11111111});
        drain("pair1", 60);
        step(2'b11, {32'h44444444, 32'h33333333});
        drain("pair2", 60);

        resp_en  = 1'b0;
        man_busy = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step(2'b10, {32'h30000000 + 32'(i), 32'h0});
        end
        idle(3);
        chk("bp_fifo_full", 32'(fifo_count), 32'd8);
        chk("bp_no_drop", 32'(drop_count), 32'(mdrop));
        step(2'b10, {32'h3000000A, 32'h0});
        idle(2);
        chk("bp_drop", 32'(drop_count), 32'(mdrop));
        chk("bp_drop_one", 32'(drop_count), 32'd1);
        resp_en = 1'b1;
        drain("backpressure", 300);

        resp_en  = 1'b0;
        man_busy = 1'b0;
        step(2'b01, {32'h0, 32'h4000000A});
        step(2'b01, {32'h0, 32'h4000000B});
        n = 0;
        while (serial_send !== 1'b1 && n < 20) begin
            step('0, '0);
            n++;
        end
        chk("tmo_send_seen", 32'(serial_send), 32'd1);
        idle(64);
        chk("tmo_before", 32'(timeout_count), 32'd0);
        idle(1);
        chk("tmo_at", 32'(timeout_count), 32'd1);
        resp_en = 1'b1;
        drain("timeout", 100);
        chk("tmo_final", 32'(timeout_count), 32'd1);

        for (int i = 0; i < 400; i++) begin
            s  = '0;
            r0 = $urandom;
            r1 = $urandom;
            v  = {r1, r0};
            if (expq.size() < 5) begin
                for (int j = 0; j < SLAVES; j++) begin
                    if ($urandom_range(0, 5) == 0) s[j] = 1'b1;
                end
            end
            step(s, v);
        end
        drain("random", 300);
        chk("random_drop", 32'(drop_count), 32'(mdrop));

        resp_en  = 1'b0;
        man_busy = 1'b0;
        step(2'b11, {32'h50000002, 32'h50000001});
        idle(2);
        step(2'b11, {32'h50000004, 32'h50000003});
        idle(2);
        man_busy = 1'b1;
        idle(4);
        chk("rst_mid_fifo", 32'(fifo_count), 32'd3);
        chk("rst_mid_model", 32'(fifo_count), 32'(expq.size()));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_send", 32'(serial_send), 32'd0);
        chk("rst_mid_fifo0", 32'(fifo_count), 32'd0);
        chk("rst_mid_drop", 32'(drop_count), 32'd0);
        chk("rst_mid_tmo", 32'(timeout_count), 32'd0);
        chk("rst_mid_golden", golden_nonce, 32'd0);
        expq.delete();
        for (int j = 0; j < SLAVES; j++) mpend[j] = 1'b0;
        mrr   = 0;
        mdrop = 0;
        @(negedge clk);
        rst_n    = 1'b1;
        man_busy = 1'b0;
        s0 = sends;
        idle(30);
        chk("rst_no_send", 32'(sends - s0), 32'd0);
        chk("rst_fifo_idle", 32'(fifo_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
